fifo_burst_reader: RTL and testbench

Read-side consumer for the latency-0 LUT-RAM FIFO: on a start request it pops exactly one burst of `pBurstLen` words from the FIFO and presents them as a valid/ready stream, flagging the final word. A two-entry skid buffer between the FIFO and the stream breaks the timing path, so `oRe` never depends combinationally on `iReady`. The block sits between the FIFO's dst side and downstream consumers, e.g. a pixel or DMA sink.

---
 rtl/fifo_burst_reader.sv | 87 ++++++++
 tb/tb_fifo_burst_reader.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/fifo_burst_reader.sv
// fifo_burst_reader: pops one pBurstLen-word burst from a latency-0 FIFO into a valid/ready stream
// through a two-entry skid buffer, so the FIFO pop never depends combinationally on iReady.
module fifo_burst_reader #(
   parameter int pBitWidth = 8,
   parameter int pBurstLen = 16,
   parameter int pCntWidth = $clog2(pBurstLen + 1)
) (
   input  logic                 iClk,
   input  logic                 iRst,
   input  logic                 iStart,
   input  logic [pBitWidth-1:0] iRd,
   input  logic                 iEmp,
   output logic                 oRe,
   output logic [pBitWidth-1:0] oData,
   output logic                 oValid,
   input  logic                 iReady,
   output logic                 oLast,
   output logic                 oBusy,
   output logic                 oDone
);
   typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;
   localparam logic [pCntWidth-1:0] LEN  = pCntWidth'(pBurstLen);
   localparam logic [pCntWidth-1:0] LAST = pCntWidth'(pBurstLen - 1);
   state_t               state_q;
   logic [pCntWidth-1:0] fetch_q, fetch_d, accept_q, accept_d;
   logic [pBitWidth-1:0] out_q, out_d, spare_q, spare_d;
   logic                 out_v_q, out_v_d, out_l_q, out_l_d;
   logic                 spare_v_q, spare_v_d, spare_l_q, spare_l_d;
   logic                 hs, pop_last, load_out, load_spare;
   assign hs         = out_v_q & iReady;
   assign oRe        = (state_q == RUN) & ~iEmp & (fetch_q < LEN) & ~spare_v_q;
   assign pop_last   = fetch_q == LAST;
   assign load_out   = oRe & (~out_v_q | hs);
   assign load_spare = oRe & out_v_q & ~hs;
   always_comb begin
      fetch_d   = fetch_q + pCntWidth'(oRe);
      accept_d  = accept_q + pCntWidth'(hs && accept_q < LEN);
      out_d     = load_out ? iRd : (hs & spare_v_q) ? spare_q : out_q;
      out_l_d   = load_out ? pop_last : (hs & spare_v_q) ? spare_l_q : out_l_q;
      out_v_d   = load_out | (hs ? spare_v_q : out_v_q);
      spare_d   = load_spare ? iRd : spare_q;
      spare_l_d = load_spare ? pop_last : spare_l_q;
      spare_v_d = load_spare | (spare_v_q & ~hs);
   end
   always_ff @(posedge iClk) begin
      if (iRst) begin
         state_q   <= IDLE;
         fetch_q   <= '0;
         accept_q  <= '0;
         out_q     <= '0;
         out_v_q   <= 1'b0;
         out_l_q   <= 1'b0;
         spare_q   <= '0;
         spare_v_q <= 1'b0;
         spare_l_q <= 1'b0;
      end else begin
         out_q     <= out_d;
         out_v_q   <= out_v_d;
         out_l_q   <= out_l_d;
         spare_q   <= spare_d;
         spare_v_q <= spare_v_d;
         spare_l_q <= spare_l_d;
         case (state_q)
            IDLE: if (iStart) begin
               state_q  <= RUN;
               fetch_q  <= '0;
               accept_q <= '0;
            end
            RUN: begin
               fetch_q  <= fetch_d;
               accept_q <= accept_d;
               if (fetch_d == LEN) state_q <= FLUSH;
            end
            FLUSH: begin
               accept_q <= accept_d;
               if (hs && accept_q == LAST) state_q <= DONE;
            end
            DONE: state_q <= IDLE;
         endcase
      end
   end
   assign oData  = out_q;
   assign oValid = out_v_q;
   assign oLast  = out_l_q & out_v_q;
   assign oBusy  = state_q != IDLE;
   assign oDone  = state_q == DONE;
endmodule

// File: tb/tb_fifo_burst_reader.sv
// tb_fifo_burst_reader: queue-modelled FIFOs feed an 8-word and a 1-word burst reader; each
// delivered burst is compared against the words the FIFO held when the burst started.
module tb_fifo_burst_reader;
   localparam int LA = 8;
   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic rst = 1'b1, start_a = 1'b0, ready_a = 1'b0, emp_a = 1'b1;
   logic start_b = 1'b0, ready_b = 1'b1, emp_b = 1'b1;
   logic [7:0] rd_a = 8'h00, rd_b = 8'h00, data_a, data_b;
   logic re_a, valid_a, last_a, busy_a, done_a, re_b, valid_b, last_b, busy_b, done_b;
   int vecs = 0, errs = 0, cyc = 0, pops_a = 0, hss_a = 0, pops_b = 0, p0 = 0;
   int done_cnt = 0, done_b_cnt = 0, cyc_fv = -1, cyc_last = -1, cyc_done = -1, viol = 0;
   logic s_re, s_v, s_busy, s_hs, s_reb;
   logic [7:0] s_data;
   logic [7:0] fifo_a[$], fifo_b[$], got_d[$], got_b[$], exp[$];
   logic got_l[$], got_bl[$];

   fifo_burst_reader #(.pBitWidth(8), .pBurstLen(LA)) dut_a (
      .iClk(clk), .iRst(rst), .iStart(start_a), .iRd(rd_a), .iEmp(emp_a), .oRe(re_a),
      .oData(data_a), .oValid(valid_a), .iReady(ready_a), .oLast(last_a), .oBusy(busy_a), .oDone(done_a));
   fifo_burst_reader #(.pBitWidth(8), .pBurstLen(1)) dut_b (
      .iClk(clk), .iRst(rst), .iStart(start_b), .iRd(rd_b), .iEmp(emp_b), .oRe(re_b),
      .oData(data_b), .oValid(valid_b), .iReady(ready_b), .oLast(last_b), .oBusy(busy_b), .oDone(done_b));

   task automatic sync();
      rd_a  = fifo_a.size() > 0 ? fifo_a[0] : 8'h00;
      emp_a = fifo_a.size() == 0;
      rd_b  = fifo_b.size() > 0 ? fifo_b[0] : 8'h00;
      emp_b = fifo_b.size() == 0;
   endtask

   task automatic push(input int n);
      for (int i = 0; i < n; i++) fifo_a.push_back(8'($urandom));
      sync();
   endtask

   task automatic clear();
      got_d.delete(); got_l.delete(); got_b.delete(); got_bl.delete();
      done_cnt = 0; done_b_cnt = 0; cyc_fv = -1; cyc_last = -1; cyc_done = -1; viol = 0; p0 = pops_a;
   endtask

   // Sample at the falling edge, then apply FIFO pops on the rising edge the DUT sees them.
   task automatic step();
      @(negedge clk);
      cyc++;
      s_re = re_a; s_v = valid_a; s_busy = busy_a; s_data = data_a; s_hs = valid_a & ready_a; s_reb = re_b;
      if (s_hs) begin got_d.push_back(data_a); got_l.push_back(last_a); if (last_a) cyc_last = cyc; end
      if (re_a && (emp_a || pops_a - hss_a >= 2)) viol++;
      if (done_a) begin done_cnt++; cyc_done = cyc; end
      if (valid_a && cyc_fv < 0) cyc_fv = cyc;
      if (valid_b && ready_b) begin got_b.push_back(data_b); got_bl.push_back(last_b); end
      if (done_b) done_b_cnt++;
      @(posedge clk);
      if (s_re && fifo_a.size() > 0) begin void'(fifo_a.pop_front()); pops_a++; end
      if (s_hs) hss_a++;
      if (s_reb && fifo_b.size() > 0) begin void'(fifo_b.pop_front()); pops_b++; end
      #1 sync();
   endtask

   task automatic test_reset();
      rst = 1'b1; step(); step();
      vecs++; if (re_a !== 1'b0) begin errs++; $display("FAIL reset_re got %b exp 0", re_a); end
      vecs++; if ({valid_a, last_a, busy_a, done_a} !== 4'b0) begin errs++; $display("FAIL reset_flags got %b exp 0000", {valid_a, last_a, busy_a, done_a}); end
      vecs++; if (data_a !== 8'h00) begin errs++; $display("FAIL reset_data got %h exp 00", data_a); end
      vecs++; if ({re_b, valid_b, busy_b, done_b} !== 4'b0) begin errs++; $display("FAIL reset_b got %b exp 0000", {re_b, valid_b, busy_b, done_b}); end
      rst = 1'b0; hss_a = pops_a;
   endtask

   task automatic test_basic();
      int s0;
      clear(); push(LA + 2); exp = fifo_a; ready_a = 1'b1;
      start_a = 1'b1; step(); s0 = cyc; start_a = 1'b0;
      for (int i = 0; i < 60 && done_cnt == 0; i++) step();
      step();
      vecs++; if (done_cnt !== 1) begin errs++; $display("FAIL basic_done got %0d exp 1", done_cnt); end
      vecs++; if (got_d.size() !== LA) begin errs++; $display("FAIL basic_count got %0d exp %0d", got_d.size(), LA); end
      for (int i = 0; i < LA && i < got_d.size(); i++) begin
         vecs++; if (got_d[i] !== exp[i] || got_l[i] !== (i == LA - 1)) begin errs++; $display("FAIL basic_word[%0d] got %h/%b exp %h/%b", i, got_d[i], got_l[i], exp[i], i == LA - 1); end
      end
      vecs++; if (cyc_fv - s0 !== 2) begin errs++; $display("FAIL basic_latency got %0d exp 2", cyc_fv - s0); end
      vecs++; if (cyc_last - cyc_fv !== LA - 1) begin errs++; $display("FAIL basic_throughput got %0d exp %0d", cyc_last - cyc_fv, LA - 1); end
      vecs++; if (cyc_done - cyc_last !== 1) begin errs++; $display("FAIL basic_done_timing got %0d exp 1", cyc_done - cyc_last); end
      vecs++; if (s_busy !== 1'b0) begin errs++; $display("FAIL basic_idle got %b exp 0", s_busy); end
      vecs++; if (pops_a - p0 !== LA || fifo_a.size() !== 2) begin errs++; $display("FAIL basic_pops got %0d left %0d exp %0d left 2", pops_a - p0, fifo_a.size(), LA); end
      fifo_a.delete(); sync();
   endtask

   task automatic test_backpressure();
      clear(); push(LA + 1); exp = fifo_a; ready_a = 1'b0;
      start_a = 1'b1; step(); start_a = 1'b0;
      for (int i = 0; i < 10 && !s_v; i++) step();
      for (int i = 0; i < 5; i++) begin
         step();
         vecs++; if (s_v !== 1'b1 || s_data !== exp[0]) begin errs++; $display("FAIL bp_hold[%0d] got %b/%h exp 1/%h", i, s_v, s_data, exp[0]); end
      end
      vecs++; if (pops_a - p0 !== 2) begin errs++; $display("FAIL bp_pops got %0d exp 2", pops_a - p0); end
      ready_a = 1'b1;
      for (int i = 0; i < 60 && done_cnt == 0; i++) step();
      vecs++; if (got_d.size() !== LA || done_cnt !== 1 || viol !== 0) begin errs++; $display("FAIL bp_burst got n=%0d done=%0d viol=%0d exp n=%0d done=1 viol=0", got_d.size(), done_cnt, viol, LA); end
      for (int i = 0; i < LA && i < got_d.size(); i++) begin
         vecs++; if (got_d[i] !== exp[i] || got_l[i] !== (i == LA - 1)) begin errs++; $display("FAIL bp_word[%0d] got %h/%b exp %h/%b", i, got_d[i], got_l[i], exp[i], i == LA - 1); end
      end
      fifo_a.delete(); sync();
   endtask

   task automatic test_underflow();
      clear(); push(2); exp = fifo_a; ready_a = 1'b1;
      start_a = 1'b1; step(); start_a = 1'b0;
      for (int i = 0; i < 10; i++) step();
      vecs++; if (s_busy !== 1'b1 || s_re !== 1'b0) begin errs++; $display("FAIL uf_stall got busy=%b re=%b exp busy=1 re=0", s_busy, s_re); end
      vecs++; if (got_d.size() !== 2 || pops_a - p0 !== 2) begin errs++; $display("FAIL uf_partial got n=%0d pops=%0d exp 2/2", got_d.size(), pops_a - p0); end
      push(LA - 2 + 3);
      for (int i = 0; i < LA - 2; i++) exp.push_back(fifo_a[i]);
      for (int i = 0; i < 60 && done_cnt == 0; i++) step();
      vecs++; if (got_d.size() !== LA || viol !== 0 || fifo_a.size() !== 3) begin errs++; $display("FAIL uf_burst got n=%0d viol=%0d left=%0d exp %0d/0/3", got_d.size(), viol, fifo_a.size(), LA); end
      for (int i = 0; i < LA && i < got_d.size(); i++) begin
         vecs++; if (got_d[i] !== exp[i] || got_l[i] !== (i == LA - 1)) begin errs++; $display("FAIL uf_word[%0d] got %h/%b exp %h/%b", i, got_d[i], got_l[i], exp[i], i == LA - 1); end
      end
      fifo_a.delete(); sync();
   endtask

   task automatic test_random();
      for (int b = 0; b < 4; b++) begin
         clear(); push(LA + int'($urandom_range(0, 3))); exp = fifo_a;
         ready_a = 1'($urandom_range(0, 1)); start_a = 1'b1; step(); start_a = 1'b0;
         for (int i = 0; i < 300 && done_cnt == 0; i++) begin ready_a = 1'($urandom_range(0, 1)); step(); end
         vecs++; if (got_d.size() !== LA || done_cnt !== 1 || viol !== 0 || pops_a - p0 !== LA) begin errs++; $display("FAIL rnd%0d got n=%0d done=%0d viol=%0d pops=%0d exp %0d/1/0/%0d", b, got_d.size(), done_cnt, viol, pops_a - p0, LA, LA); end
         for (int i = 0; i < LA && i < got_d.size(); i++) begin
            vecs++; if (got_d[i] !== exp[i] || got_l[i] !== (i == LA - 1)) begin errs++; $display("FAIL rnd%0d_word[%0d] got %h/%b exp %h/%b", b, i, got_d[i], got_l[i], exp[i], i == LA - 1); end
         end
         fifo_a.delete(); sync();
      end
   endtask

   task automatic test_reset_mid();
      clear(); push(3 * LA); ready_a = 1'b1;
      start_a = 1'b1; step(); start_a = 1'b0;
      for (int i = 0; i < 20 && got_d.size() < 3; i++) step();
      rst = 1'b1; step(); rst = 1'b0; hss_a = pops_a;
      vecs++; if ({valid_a, busy_a, re_a} !== 3'b000) begin errs++; $display("FAIL rmid_state got %b exp 000", {valid_a, busy_a, re_a}); end
      clear(); exp = fifo_a;
      start_a = 1'b1; step(); start_a = 1'b0;
      for (int i = 0; i < 60 && done_cnt == 0; i++) step();
      vecs++; if (got_d.size() !== LA || done_cnt !== 1) begin errs++; $display("FAIL rmid_burst got n=%0d done=%0d exp %0d/1", got_d.size(), done_cnt, LA); end
      for (int i = 0; i < LA && i < got_d.size(); i++) begin
         vecs++; if (got_d[i] !== exp[i] || got_l[i] !== (i == LA - 1)) begin errs++; $display("FAIL rmid_word[%0d] got %h/%b exp %h/%b", i, got_d[i], got_l[i], exp[i], i == LA - 1); end
      end
      fifo_a.delete(); sync();
   endtask

   task automatic test_len1();
      logic [7:0] first;
      clear();
      for (int i = 0; i < 3; i++) fifo_b.push_back(8'($urandom));
      sync(); first = fifo_b[0]; p0 = pops_b;
      start_b = 1'b1; step(); start_b = 1'b0;
      for (int i = 0; i < 20 && done_b_cnt == 0; i++) step();
      vecs++; if (got_b.size() !== 1 || done_b_cnt !== 1) begin errs++; $display("FAIL len1_count got n=%0d done=%0d exp 1/1", got_b.size(), done_b_cnt); end
      vecs++; if (got_b.size() > 0 && (got_b[0] !== first || got_bl[0] !== 1'b1)) begin errs++; $display("FAIL len1_word got %h/%b exp %h/1", got_b[0], got_bl[0], first); end
      vecs++; if (pops_b - p0 !== 1 || fifo_b.size() !== 2) begin errs++; $display("FAIL len1_pops got %0d left %0d exp 1 left 2", pops_b - p0, fifo_b.size()); end
   endtask

   task automatic test_start_held();
      int m;
      clear(); push(2 * LA + 2); exp = fifo_a; ready_a = 1'b1; start_a = 1'b1;
      for (int i = 0; i < 60 && done_cnt == 0; i++) step();
      m = cyc_last;
      vecs++; if (cyc_done - m !== 1) begin errs++; $display("FAIL held_done got %0d exp 1", cyc_done - m); end
      step();
      vecs++; if (cyc - m !== 2 || s_busy !== 1'b0 || s_re !== 1'b0) begin errs++; $display("FAIL held_idle got dc=%0d busy=%b re=%b exp 2/0/0", cyc - m, s_busy, s_re); end
      step(); start_a = 1'b0;
      vecs++; if (s_busy !== 1'b1 || s_re !== 1'b1) begin errs++; $display("FAIL held_restart got busy=%b re=%b exp 1/1", s_busy, s_re); end
      for (int i = 0; i < 60 && done_cnt < 2; i++) step();
      vecs++; if (got_d.size() !== 2 * LA || done_cnt !== 2) begin errs++; $display("FAIL held_count got n=%0d done=%0d exp %0d/2", got_d.size(), done_cnt, 2 * LA); end
      for (int i = 0; i < 2 * LA && i < got_d.size(); i++) begin
         vecs++; if (got_d[i] !== exp[i] || got_l[i] !== (i % LA == LA - 1)) begin errs++; $display("FAIL held_word[%0d] got %h/%b exp %h/%b", i, got_d[i], got_l[i], exp[i], i % LA == LA - 1); end
      end
      fifo_a.delete(); sync();
   endtask

   initial begin
      test_reset();
      test_basic();
      test_backpressure();
      test_underflow();
      test_random();
      test_reset_mid();
      test_len1();
      test_start_held();
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end
endmodule
